// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width, EX operand-select
// encodings and the destination-tag slot carried down the shadow pipeline.
package pipe_pkg;
  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic              regwrite;
    logic              memread;
  } slot_t;
endpackage

// File: rtl/fwd_sel_calc.sv
// Next-cycle forwarding select for one EX operand, evaluated while the
// consuming instruction is still in ID.
module fwd_sel_calc
  import pipe_pkg::*;
#(
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              use_src,
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_regwrite,
  output logic [1:0]        sel
);

  // The instruction now in EX is the newest producer, so it wins over MEM.
  // $0 is hard-wired zero and is never forwarded.
  always_comb begin
    sel = FWD_IDEX;
    if (use_src && ex_regwrite && (ex_dest != '0) && (ex_dest == src))
      sel = FWD_EXMEM;
    else if (use_src && mem_regwrite && (mem_dest != '0) && (mem_dest == src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand-forwarding selects and load-use hazard detection, driven from a
// shadow pipeline of destination tags for the EX, MEM and WB stages.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  input  logic              mem_hold,
  output logic [1:0]        forwarding_output1,
  output logic [1:0]        forwarding_output2,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_count
);

  slot_t      ex_slot, mem_slot, wb_slot;
  logic       luh;
  logic [1:0] sel1_next, sel2_next;
  logic       unused_wb;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_rs (
    .use_src      (id_use_rs),
    .src          (id_rs),
    .ex_dest      (ex_slot.dest),
    .ex_regwrite  (ex_slot.regwrite),
    .mem_dest     (mem_slot.dest),
    .mem_regwrite (mem_slot.regwrite),
    .sel          (sel1_next)
  );

  fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_rt (
    .use_src      (id_use_rt),
    .src          (id_rt),
    .ex_dest      (ex_slot.dest),
    .ex_regwrite  (ex_slot.regwrite),
    .mem_dest     (mem_slot.dest),
    .mem_regwrite (mem_slot.regwrite),
    .sel          (sel2_next)
  );

  // A load in EX cannot forward its data in time; the reader must wait one cycle.
  always_comb begin
    luh = id_valid && ex_slot.memread && ex_slot.regwrite && (ex_slot.dest != '0) &&
          ((id_use_rs && (id_rs == ex_slot.dest)) || (id_use_rt && (id_rt == ex_slot.dest)));
  end

  assign stall  = luh && !flush && !mem_hold;
  assign bubble = (luh || flush || !id_valid) && !mem_hold;

  // WB tags are tracked for completeness; the register file write-through
  // makes forwarding from WB unnecessary.
  assign unused_wb = ^wb_slot;

  // Stage boundary: ID -> EX -> MEM -> WB shadow registers and select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot            <= '0;
      mem_slot           <= '0;
      wb_slot            <= '0;
      forwarding_output1 <= FWD_IDEX;
      forwarding_output2 <= FWD_IDEX;
      stall_count        <= '0;
    end else if (!mem_hold) begin
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
      if (flush || luh) begin
        ex_slot            <= '0;
        forwarding_output1 <= FWD_IDEX;
        forwarding_output2 <= FWD_IDEX;
        if (!flush)
          stall_count <= sat_inc(stall_count);
      end else begin
        ex_slot.dest       <= id_dest;
        ex_slot.regwrite   <= id_regwrite && id_valid;
        ex_slot.memread    <= id_memread && id_valid;
        forwarding_output1 <= sel1_next;
        forwarding_output2 <= sel2_next;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: instruction sequences driven through ID
// with hand-computed select, stall, bubble and counter expectations.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic        flush, mem_hold;
  logic [1:0]  forwarding_output1, forwarding_output2;
  logic        stall, bubble;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_valid           (id_valid),
    .id_rs              (id_rs),
    .id_rt              (id_rt),
    .id_use_rs          (id_use_rs),
    .id_use_rt          (id_use_rt),
    .id_dest            (id_dest),
    .id_regwrite        (id_regwrite),
    .id_memread         (id_memread),
    .flush              (flush),
    .mem_hold           (mem_hold),
    .forwarding_output1 (forwarding_output1),
    .forwarding_output2 (forwarding_output2),
    .stall              (stall),
    .bubble             (bubble),
    .stall_count        (stall_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] d,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dest = d; id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic idle(input int n);
    flush = 1'b0; mem_hold = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mem_hold = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    #3;
    checks++; if (forwarding_output1 !== 2'b00) begin errors++; $display("FAIL reset_fwd1: got %b expected 00", forwarding_output1); end
    checks++; if (forwarding_output2 !== 2'b00) begin errors++; $display("FAIL reset_fwd2: got %b expected 00", forwarding_output2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b expected 0", bubble); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
    step();
    rst_n = 1'b1;
    idle(3);
  endtask

  // add $3,$1,$2 ; sub $4,$3,$5
  task automatic test_ex_forward();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL exfwd_stall_add: got %b expected 0", stall); end
    step();
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL exfwd_stall_sub: got %b expected 0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL exfwd_bubble_sub: got %b expected 0", bubble); end
    step();
    checks++; if (forwarding_output1 !== 2'b10) begin errors++; $display("FAIL exfwd_fwd1: got %b expected 10", forwarding_output1); end
    checks++; if (forwarding_output2 !== 2'b00) begin errors++; $display("FAIL exfwd_fwd2: got %b expected 00", forwarding_output2); end
    idle(3);
  endtask

  // add $3 ; nop ; or $6,$3,$3
  task automatic test_mem_forward();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    step();
    checks++; if (forwarding_output1 !== 2'b01) begin errors++; $display("FAIL memfwd_fwd1: got %b expected 01", forwarding_output1); end
    checks++; if (forwarding_output2 !== 2'b01) begin errors++; $display("FAIL memfwd_fwd2: got %b expected 01", forwarding_output2); end
    idle(3);
  endtask

  // lw $7,0($1) ; and $8,$7,$2
  task automatic test_load_use();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall); end
    checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b expected 1", bubble); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL lu_count_before: got %0d expected 0", stall_count); end
    step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_after: got %b expected 0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL lu_bubble_after: got %b expected 0", bubble); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count_after: got %0d expected 1", stall_count); end
    checks++; if (forwarding_output1 !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd1: got %b expected 00", forwarding_output1); end
    step();
    checks++; if (forwarding_output1 !== 2'b01) begin errors++; $display("FAIL lu_fwd1: got %b expected 01", forwarding_output1); end
    checks++; if (forwarding_output2 !== 2'b00) begin errors++; $display("FAIL lu_fwd2: got %b expected 00", forwarding_output2); end
    idle(3);
  endtask

  // addi $0,$0,5 then reader of $0; lw $0 then reader of $0
  task automatic test_zero_reg();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall_alu: got %b expected 0", stall); end
    step();
    checks++; if (forwarding_output1 !== 2'b00) begin errors++; $display("FAIL zero_fwd1: got %b expected 00", forwarding_output1); end
    checks++; if (forwarding_output2 !== 2'b00) begin errors++; $display("FAIL zero_fwd2: got %b expected 00", forwarding_output2); end
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall_load: got %b expected 0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL zero_bubble_load: got %b expected 0", bubble); end
    step();
    checks++; if (forwarding_output1 !== 2'b00) begin errors++; $display("FAIL zero_load_fwd1: got %b expected 00", forwarding_output1); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL zero_count: got %0d expected 1", stall_count); end
    idle(3);
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    flush = 1'b1;
    set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
    checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL flush_bubble: got %b expected 1", bubble); end
    step();
    flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", stall_count); end
    checks++; if (forwarding_output1 !== 2'b00) begin errors++; $display("FAIL flush_fwd1: got %b expected 00", forwarding_output1); end
    idle(3);
  endtask

  // add $3 ; lw $7,0($3) ; and $8,$7,$2 arriving under a 3-cycle mem_hold
  task automatic test_mem_hold();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    checks++; if (forwarding_output1 !== 2'b10) begin errors++; $display("FAIL hold_pre_fwd1: got %b expected 10", forwarding_output1); end
    mem_hold = 1'b1;
    set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_stall: got %b expected 0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL hold_bubble: got %b expected 0", bubble); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (forwarding_output1 !== 2'b10) begin errors++; $display("FAIL hold_frozen_fwd1[%0d]: got %b expected 10", i, forwarding_output1); end
      checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL hold_frozen_count[%0d]: got %0d expected 1", i, stall_count); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_frozen_stall[%0d]: got %b expected 0", i, stall); end
    end
    mem_hold = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall: got %b expected 1", stall); end
    checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL hold_release_bubble: got %b expected 1", bubble); end
    step();
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL hold_count: got %0d expected 2", stall_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_resolved_stall: got %b expected 0", stall); end
    step();
    checks++; if (forwarding_output1 !== 2'b01) begin errors++; $display("FAIL hold_fwd1: got %b expected 01", forwarding_output1); end
    idle(3);
  endtask

  // lw $7 ; lw $9,0($7) ; add $10,$9,$0
  task automatic test_back_to_back();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1: got %b expected 1", stall); end
    step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall1_end: got %b expected 0", stall); end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL b2b_count1: got %0d expected 3", stall_count); end
    step();
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    checks++; if (forwarding_output1 !== 2'b01) begin errors++; $display("FAIL b2b_lw_fwd1: got %b expected 01", forwarding_output1); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2: got %b expected 1", stall); end
    step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall2_end: got %b expected 0", stall); end
    checks++; if (stall_count !== 16'd4) begin errors++; $display("FAIL b2b_count2: got %0d expected 4", stall_count); end
    step();
    checks++; if (forwarding_output1 !== 2'b01) begin errors++; $display("FAIL b2b_add_fwd1: got %b expected 01", forwarding_output1); end
    idle(3);
  endtask

  task automatic test_reset_midstall();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    idle(3);
    checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL mid_count5: got %0d expected 5", stall_count); end
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %b expected 1", stall); end
    checks++; if (forwarding_output1 !== 2'b10) begin errors++; $display("FAIL mid_fwd1_pre: got %b expected 10", forwarding_output1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (forwarding_output1 !== 2'b00) begin errors++; $display("FAIL mid_fwd1: got %b expected 00", forwarding_output1); end
    checks++; if (forwarding_output2 !== 2'b00) begin errors++; $display("FAIL mid_fwd2: got %b expected 00", forwarding_output2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b expected 0", stall); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", stall_count); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_release_stall: got %b expected 0", stall); end
    step();
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL mid_release_count: got %0d expected 0", stall_count); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_mem_hold();
    test_back_to_back();
    test_reset_midstall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
